// File: rtl/io_uart_port.sv
// IO-port UART: decodes IO_Command_Bus, serves IO_Bus reads/writes, 8N1 serial TX/RX with FIFOs.
// Reads are combinational from registered state; a held command acts once; TX-full writes drop silently.

module io_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PTR_ONE;
      if (pop_i && !empty_o) rptr_q <= rptr_q + PTR_ONE;
    end
  end
endmodule

module io_uart_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IO_Command_Bus,
  inout  wire  [7:0] IO_Bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0] CMD_RD = 8'h01, CMD_ST = 8'h02, CMD_PK = 8'h03, CMD_WR = 8'h04;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;

  logic [7:0] prev_cmd_q;
  logic       wr_pend_q, undf_q, ferr_q, ovr_q, irq_q;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  st_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;

  logic       cmd_valid, cmd_start, bus_oe, st_clr, undf_evt, ovr_evt, ferr_evt;
  logic       rx_push, rx_pop, rx_empty, rx_full, tx_pop, tx_empty, tx_full, tx_busy;
  logic [7:0] rx_head, tx_head, status, rd_dat;

  assign cmd_valid = (IO_Command_Bus >= CMD_RD) && (IO_Command_Bus <= CMD_WR);
  assign cmd_start = cmd_valid && (IO_Command_Bus != prev_cmd_q);
  assign bus_oe    = (IO_Command_Bus == CMD_RD) || (IO_Command_Bus == CMD_ST) ||
                     (IO_Command_Bus == CMD_PK);
  assign st_clr    = cmd_start && (IO_Command_Bus == CMD_ST);
  assign undf_evt  = cmd_start && (IO_Command_Bus == CMD_RD) && rx_empty;
  assign rx_pop    = cmd_start && (IO_Command_Bus == CMD_RD) && !rx_empty;
  assign tx_busy   = (tx_state_q != S_IDLE);

  assign status = {undf_q, ferr_q, ovr_q, tx_busy, tx_empty, tx_full, rx_full, !rx_empty};
  assign rd_dat = (IO_Command_Bus == CMD_ST) ? status : (rx_empty ? 8'h00 : rx_head);
  assign IO_Bus = bus_oe ? rd_dat : 8'bz;
  assign irq    = irq_q;

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push_i(wr_pend_q), .push_dat_i(IO_Bus),
    .pop_i(tx_pop), .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push_i(rx_push), .push_dat_i(rx_sh_q),
    .pop_i(rx_pop), .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_state_d = S_START;
        end
      end
      S_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0; tx_bit_d = 3'd0; tx_state_d = S_DATA;
      end
      S_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end
      default: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        // Chain straight into the next start bit when more data is queued.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
    endcase
    uart_tx = (tx_state_q == S_START) ? 1'b0 : (tx_state_q == S_DATA) ? tx_sh_q[0] : 1'b1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_ONE;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ovr_evt    = 1'b0;
    ferr_evt   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_END) begin
        // Line back high at mid-start is a glitch, not a frame.
        rx_cnt_d = '0; rx_bit_d = 3'd0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      default: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (rx_s2_q) begin
          rx_push = 1'b1; ovr_evt = rx_full;
        end else begin
          ferr_evt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_cmd_q <= 8'h00;
      wr_pend_q  <= 1'b0;
      undf_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
    end else begin
      prev_cmd_q <= IO_Command_Bus;
      wr_pend_q  <= cmd_start && (IO_Command_Bus == CMD_WR);
      undf_q     <= (undf_q & ~st_clr) | undf_evt;
      ferr_q     <= (ferr_q & ~st_clr) | ferr_evt;
      ovr_q      <= (ovr_q & ~st_clr) | ovr_evt;
      irq_q      <= !rx_empty | ovr_q | ferr_q | undf_q;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end
endmodule

// File: tb/tb_io_uart_port.sv
// Bench for io_uart_port: IO commands, TX framing, RX framing, sticky flags and FIFO limits.
// Expected RX/TX bytes are queued when stimulus is driven and popped when the DUT returns them.

module tb_io_uart_port;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cmd;
  wire  [7:0] io_bus;
  logic       tb_oe;
  logic [7:0] tb_dat;
  logic       uart_rx;
  logic       uart_tx;
  logic       irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc_cnt = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  assign io_bus = tb_oe ? tb_dat : 8'bz;

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  io_uart_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .IO_Command_Bus(cmd), .IO_Bus(io_bus),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  task automatic rd(input logic [7:0] c, output logic [7:0] d);
    @(posedge clock); #1 cmd = c;
    @(negedge clock); d = io_bus;
    @(posedge clock); #1 cmd = 8'h00;
  endtask

  task automatic wr(input logic [7:0] b);
    @(posedge clock); #1 cmd = 8'h04;
    @(posedge clock); #1 tb_oe = 1'b1; tb_dat = b;
    @(posedge clock); #1 cmd = 8'h00; tb_oe = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic find_start(output logic found, output int start_c);
    found = 1'b0;
    start_c = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (uart_tx == 1'b0) begin
        found = 1'b1;
        start_c = cyc_cnt;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1; cmd = 8'h00; tb_oe = 1'b0; tb_dat = 8'h00; uart_rx = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", uart_tx); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL reset_status: got %h expected 08", d); else pass_cnt++;
    @(posedge clock); #1 tb_oe = 1'b1; tb_dat = 8'hA5;
    @(negedge clock);
    total_cnt++;
    if (io_bus !== 8'hA5) $display("FAIL idle_bus_released: got %h expected a5", io_bus); else pass_cnt++;
    @(posedge clock); #1 tb_oe = 1'b0;
  endtask

  task automatic test_tx;
    logic [7:0] d, exp;
    logic [9:0] bits;
    logic found;
    int start_c;
    tx_exp.push_back(8'h55);
    @(posedge clock); #1 cmd = 8'h04;
    @(posedge clock); #1 tb_oe = 1'b1; tb_dat = 8'h55;
    @(negedge clock);
    total_cnt++;
    if (io_bus !== 8'h55) $display("FAIL wr_bus_not_driven: got %h expected 55", io_bus); else pass_cnt++;
    @(posedge clock); #1 cmd = 8'h00; tb_oe = 1'b0;
    find_start(found, start_c);
    total_cnt++;
    if (found !== 1'b1) $display("FAIL tx_start_seen: got %b expected 1", found); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h18) $display("FAIL tx_busy_status: got %h expected 18", d); else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      while (cyc_cnt < start_c + CPB/2 + k*CPB) @(negedge clock);
      bits[k] = uart_tx;
    end
    exp = tx_exp.pop_front();
    total_cnt++;
    if (bits !== {1'b1, exp, 1'b0}) $display("FAIL tx_frame: got %b expected %b", bits, {1'b1, exp, 1'b0});
    else pass_cnt++;
    while (cyc_cnt < start_c + 10*CPB + 2) @(negedge clock);
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL tx_done_status: got %h expected 08", d); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    logic [9:0] bits;
    logic found;
    int start_c;
    tx_exp.push_back(8'hA5);
    tx_exp.push_back(8'h3C);
    wr(8'hA5);
    find_start(found, start_c);
    total_cnt++;
    if (found !== 1'b1) $display("FAIL b2b_start_seen: got %b expected 1", found); else pass_cnt++;
    wr(8'h3C);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10; k++) begin
        while (cyc_cnt < start_c + f*10*CPB + CPB/2 + k*CPB) @(negedge clock);
        bits[k] = uart_tx;
      end
      exp = tx_exp.pop_front();
      total_cnt++;
      if (bits !== {1'b1, exp, 1'b0})
        $display("FAIL b2b_frame%0d: got %b expected %b", f, bits, {1'b1, exp, 1'b0});
      else pass_cnt++;
    end
    repeat (CPB) @(posedge clock);
  endtask

  task automatic test_rx_peek;
    logic [7:0] d;
    rx_exp.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    repeat (4) @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      rd(8'h03, d);
      total_cnt++;
      if (d !== rx_exp[0]) $display("FAIL rx_peek%0d: got %h expected %h", i, d, rx_exp[0]); else pass_cnt++;
    end
    rd(8'h01, d);
    total_cnt++;
    if (d !== rx_exp[0]) $display("FAIL rx_pop: got %h expected %h", d, rx_exp[0]); else pass_cnt++;
    void'(rx_exp.pop_front());
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL rx_after_pop_status: got %h expected 08", d); else pass_cnt++;
  endtask

  task automatic test_overrun;
    logic [7:0] d, b;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(8'h11 * (i + 1));
      if (i < DEPTH) rx_exp.push_back(b);
      send_rx(b, 1'b1);
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL ovr_irq: got %b expected 1", irq); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h2B) $display("FAIL ovr_status: got %h expected 2b", d); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h0B) $display("FAIL ovr_cleared: got %h expected 0b", d); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      rd(8'h01, d);
      total_cnt++;
      if (d !== rx_exp[0]) $display("FAIL ovr_data%0d: got %h expected %h", i, d, rx_exp[0]); else pass_cnt++;
      void'(rx_exp.pop_front());
    end
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL ovr_drained_status: got %h expected 08", d); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL ovr_irq_clear: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_underflow;
    logic [7:0] d, exp;
    rd(8'h01, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL undf_data: got %h expected 00", d); else pass_cnt++;
    repeat (2) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL undf_irq: got %b expected 1", irq); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h88) $display("FAIL undf_status: got %h expected 88", d); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL undf_cleared: got %h expected 08", d); else pass_cnt++;
    rx_exp.push_back(8'h5C);
    rx_exp.push_back(8'hE7);
    send_rx(8'h5C, 1'b1);
    send_rx(8'hE7, 1'b1);
    repeat (4) @(posedge clock);
    #1 cmd = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) exp = rx_exp.pop_front(); else exp = rx_exp[0];
      total_cnt++;
      if (io_bus !== exp) $display("FAIL hold_rd%0d: got %h expected %h", i, io_bus, exp); else pass_cnt++;
      @(posedge clock); #1;
    end
    cmd = 8'h00;
    rd(8'h01, d);
    exp = rx_exp.pop_front();
    total_cnt++;
    if (d !== exp) $display("FAIL hold_single_pop: got %h expected %h", d, exp); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL hold_status: got %h expected 08", d); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    send_rx(8'h3C, 1'b0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL ferr_irq: got %b expected 1", irq); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h48) $display("FAIL ferr_status: got %h expected 48", d); else pass_cnt++;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL ferr_cleared: got %h expected 08", d); else pass_cnt++;
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (CPB/2 - 3) @(posedge clock);
    #1 uart_rx = 1'b1;
    repeat (3*CPB) @(posedge clock);
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL glitch_status: got %h expected 08", d); else pass_cnt++;
    rd(8'h03, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL glitch_peek: got %h expected 00", d); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic found;
    int start_c;
    wr(8'hC3);
    find_start(found, start_c);
    total_cnt++;
    if (found !== 1'b1) $display("FAIL rst_mid_start_seen: got %b expected 1", found); else pass_cnt++;
    repeat (CPB) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (uart_tx !== 1'b1) $display("FAIL rst_mid_tx: got %b expected 1 (start at %0d)", uart_tx, start_c);
    else pass_cnt++;
    @(posedge clock); #1 reset = 1'b0;
    rd(8'h02, d);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL rst_mid_status: got %h expected 08", d); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx_peek();
    test_overrun();
    test_underflow();
    test_frame_err();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule
